// File: rtl/modport_memory.sv
// modport_memory: 8x8 single-port synchronous RAM with registered read-before-write reads.
// Async active-low reset clears both the storage and the read register.
module modport_memory #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   // mem_q is sampled before this edge's write lands, giving read-before-write
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) rdata_d = mem_q[addr];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rdata_q <= '0;
      end else begin
         if (wr_en) mem_q[addr] <= wdata;
         rdata_q <= rdata_d;
      end
   end
   assign rdata = rdata_q;
endmodule

// File: tb/tb_modport_memory.sv
// tb_modport_memory: directed checks of reset, write/read, sweep, collision, hold and async reset.
module tb_modport_memory;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] addr = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   int errors = 0;
   int checks = 0;

   modport_memory dut (
      .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en),
      .rd_en(rd_en), .wdata(wdata), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // inputs change 1 time unit after the edge, outputs sampled there too
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d);
      wr_en = w;
      rd_en = r;
      addr  = a;
      wdata = d;
   endtask

   initial begin
      #1 reset = 1'b0;
      step();
      step();
      check("reset_rdata", rdata, 8'h00);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 3'(i), 8'h00);
         step();
         check($sformatf("reset_mem%0d", i), rdata, 8'h00);
      end
      drive(1'b1, 1'b0, 3'd3, 8'hA5);
      step();
      check("write_no_rdata_change", rdata, 8'h00);
      drive(1'b0, 1'b1, 3'd3, 8'h00);
      step();
      check("rd3", rdata, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 3'(i), 8'h10 + 8'(i));
         step();
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 3'(i), 8'h00);
         step();
         check($sformatf("sweep%0d", i), rdata, 8'h10 + 8'(i));
      end
      drive(1'b1, 1'b0, 3'd5, 8'h11);
      step();
      drive(1'b1, 1'b1, 3'd5, 8'h22);
      step();
      check("collide_old", rdata, 8'h11);
      drive(1'b0, 1'b1, 3'd5, 8'h00);
      step();
      check("collide_new", rdata, 8'h22);
      drive(1'b1, 1'b0, 3'd2, 8'hA5);
      step();
      drive(1'b0, 1'b1, 3'd2, 8'h00);
      step();
      check("hold_rd", rdata, 8'hA5);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 3'(4 + i), 8'hC0 + 8'(i));
         step();
         check($sformatf("hold%0d", i), rdata, 8'hA5);
      end
      drive(1'b0, 1'b1, 3'd6, 8'h00);
      step();
      check("hold_wr_landed", rdata, 8'hC2);
      drive(1'b0, 1'b0, 3'd0, 8'h00);
      #2 reset = 1'b0;
      #1 check("async_rdata", rdata, 8'h00);
      step();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 3'(i), 8'h00);
         step();
         check($sformatf("async_mem%0d", i), rdata, 8'h00);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
